// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Inputs are snapshotted once per frame; leading-zero blanking and decimal points are supported.
module seven_seg_scan #(
   parameter int DVSR = 50000,
   parameter int N    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_mask,
   input  logic        blank_lz,
   input  logic        display_en,
   output logic [3:0]  an,
   output logic [7:0]  sseg,
   output logic        frame_tick
);

   localparam logic [N-1:0] CNT_MAX = N'(DVSR - 1);
   localparam logic [N-1:0] CNT_ONE = N'(1);

   logic [N-1:0] cnt;
   logic [1:0]   sel;
   logic [15:0]  snap_digits;
   logic [3:0]   snap_dp;

   logic         dwell_done;
   logic         frame_end;
   logic [3:0]   cur_digit;
   logic         cur_blank;
   logic         zero3;
   logic         zero2;
   logic         zero1;
   logic [3:0]   an_next;
   logic [7:0]   sseg_next;

   // Active-low {g..a} patterns for hex digits 0-F.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign dwell_done = (cnt == CNT_MAX);
   assign frame_end  = dwell_done && (sel == 2'd3);

   assign zero3 = (snap_digits[15:12] == 4'd0);
   assign zero2 = (snap_digits[11:8]  == 4'd0);
   assign zero1 = (snap_digits[7:4]   == 4'd0);

   // Blanking looks at the snapshot but follows blank_lz live.
   always_comb begin
      cur_digit = 4'd0;
      cur_blank = 1'b0;
      case (sel)
         2'd0: begin
            cur_digit = snap_digits[3:0];
            cur_blank = 1'b0;
         end
         2'd1: begin
            cur_digit = snap_digits[7:4];
            cur_blank = blank_lz && zero3 && zero2 && zero1;
         end
         2'd2: begin
            cur_digit = snap_digits[11:8];
            cur_blank = blank_lz && zero3 && zero2;
         end
         default: begin
            cur_digit = snap_digits[15:12];
            cur_blank = blank_lz && zero3;
         end
      endcase
   end

   always_comb begin
      an_next   = ~(4'b0001 << sel);
      sseg_next = {~snap_dp[sel], (cur_blank ? 7'h7F : seg_decode(cur_digit))};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         sel         <= 2'd0;
         snap_digits <= 16'h0000;
         snap_dp     <= 4'b0000;
         an          <= 4'b1111;
         sseg        <= 8'hFF;
         frame_tick  <= 1'b0;
      end else begin
         cnt        <= dwell_done ? '0 : cnt + CNT_ONE;
         frame_tick <= frame_end;
         if (dwell_done) begin
            sel <= sel + 2'd1;
         end
         if (frame_end) begin
            snap_digits <= digits;
            snap_dp     <= dp_mask;
         end
         // Scanning keeps running while dark so re-enabling resumes in place.
         if (display_en) begin
            an   <= an_next;
            sseg <= sseg_next;
         end else begin
            an   <= 4'b1111;
            sseg <= 8'hFF;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with DVSR=4: a frame-level vector table
// plus hand sequences for reset, mid-frame input changes and display enable.
module tb_seven_seg_scan;

   localparam int DVSR = 4;
   localparam int N    = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic        blank_lz;
   logic        display_en;
   logic [3:0]  an;
   logic [7:0]  sseg;
   logic        frame_tick;

   int total = 0;
   int bad   = 0;

   seven_seg_scan #(.DVSR(DVSR), .N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .digits     (digits),
      .dp_mask    (dp_mask),
      .blank_lz   (blank_lz),
      .display_en (display_en),
      .an         (an),
      .sseg       (sseg),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]     digits;
      logic [3:0]      dp;
      logic            blz;
      logic [3:0][7:0] seg;   // {digit3, digit2, digit1, digit0}
   } vec_t;

   vec_t vecs[7];

   task automatic check_out(input string name, input logic [3:0] exp_an, input logic [7:0] exp_seg);
      total++;
      if (an !== exp_an || sseg !== exp_seg) begin
         bad++;
         $display("FAIL %s: an=%b sseg=%h, required an=%b sseg=%h", name, an, sseg, exp_an, exp_seg);
      end
   endtask

   task automatic check_tick(input string name, input logic exp);
      total++;
      if (frame_tick !== exp) begin
         bad++;
         $display("FAIL %s: frame_tick=%b, required %b", name, frame_tick, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Advance negedge by negedge until frame_tick is seen; n = cycles waited.
   task automatic wait_frame(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < 64);
      if (frame_tick !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL wait_frame: no frame_tick within %0d cycles, required one", n);
      end
   endtask

   initial begin
      int n;
      logic [3:0] ea;

      vecs[0] = '{16'h1234, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
      vecs[1] = '{16'h0070, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hF8, 8'hC0}};
      vecs[2] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
      vecs[3] = '{16'h0595, 4'b0100, 1'b0, {8'hC0, 8'h12, 8'h90, 8'h92}};
      vecs[4] = '{16'hABCD, 4'b1001, 1'b0, {8'h08, 8'h83, 8'hC6, 8'h21}};
      vecs[5] = '{16'h0E0F, 4'b0010, 1'b1, {8'hFF, 8'h86, 8'h40, 8'h8E}};
      vecs[6] = '{16'h0008, 4'b1000, 1'b1, {8'h7F, 8'hFF, 8'hFF, 8'h80}};

      reset      = 1'b1;
      digits     = 16'h0000;
      dp_mask    = 4'b0000;
      blank_lz   = 1'b0;
      display_en = 1'b1;

      // Reset held three cycles, then released with 1234 applied.
      repeat (3) begin
         @(negedge clk);
         check_out("reset_out", 4'b1111, 8'hFF);
         check_tick("reset_tick", 1'b0);
      end
      reset  = 1'b0;
      digits = 16'h1234;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         ea = ~(4'b0001 << ((k - 1) / 4));
         check_out("first_frame", ea, 8'hC0);
         check_tick("first_tick", (k == 16));
      end

      // 1234 frame; change to 5678 while digit1 is lit.
      @(negedge clk);
      check_out("f1234_d0", 4'b1110, 8'h99);
      repeat (4) @(negedge clk);
      digits = 16'h5678;
      check_out("f1234_d1", 4'b1101, 8'hB0);
      repeat (4) @(negedge clk);
      check_out("hold_d2", 4'b1011, 8'hA4);
      repeat (4) @(negedge clk);
      check_out("hold_d3", 4'b0111, 8'hF9);
      wait_frame(n);
      check_int("tick_spacing", n, 3);
      @(negedge clk);
      check_out("f5678_d0", 4'b1110, 8'h80);
      repeat (4) @(negedge clk);
      check_out("f5678_d1", 4'b1101, 8'hF8);

      // Frame-level vector table.
      for (int v = 0; v < 7; v++) begin
         digits   = vecs[v].digits;
         dp_mask  = vecs[v].dp;
         blank_lz = vecs[v].blz;
         wait_frame(n);
         for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            ea = ~(4'b0001 << d);
            check_out($sformatf("vec%0d_d%0d", v, d), ea, vecs[v].seg[d]);
            if (d < 3) repeat (3) @(negedge clk);
         end
      end

      // Display disabled mid-frame: dark next cycle, ticks keep period, position kept.
      digits   = 16'h5678;
      dp_mask  = 4'b0000;
      blank_lz = 1'b0;
      wait_frame(n);
      wait_frame(n);
      repeat (5) @(negedge clk);
      display_en = 1'b0;
      @(negedge clk);
      check_out("dis_dark", 4'b1111, 8'hFF);
      wait_frame(n);
      check_int("dis_tick_first", n, 10);
      wait_frame(n);
      check_int("dis_tick_period", n, 16);
      check_out("dis_still_dark", 4'b1111, 8'hFF);
      repeat (9) @(negedge clk);
      display_en = 1'b1;
      @(negedge clk);
      check_out("reen_pos", 4'b1011, 8'h82);

      // Reset while digit2 is lit.
      wait_frame(n);
      repeat (9) @(negedge clk);
      check_out("pre_reset", 4'b1011, 8'h82);
      reset = 1'b1;
      @(negedge clk);
      check_out("midreset_out", 4'b1111, 8'hFF);
      check_tick("midreset_tick", 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check_out("restart_d0", 4'b1110, 8'hC0);
      repeat (4) @(negedge clk);
      check_out("restart_d1", 4'b1101, 8'hC0);
      wait_frame(n);
      check_int("restart_tick", n, 11);
      @(negedge clk);
      check_out("after_restart", 4'b1110, 8'h80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Consumes the packed 4-digit BCD word from the stopwatch counter and drives a common-anode, 4-digit, time-multiplexed seven-segment display.
- Time-multiplexes the digits with a programmable per-digit dwell.
- Snapshots its inputs once per frame so a digit never changes mid-scan.
- Supports leading-zero blanking and per-digit decimal points.

Parameters:
- DVSR, 50000, clocks each digit stays lit (dwell); must be >= 2.
- N, 16, width of the dwell counter; 2^N must be > DVSR-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- digits  input  16  BCD digits {d3,d2,d1,d0}; d0 is rightmost. Codes 10-15 are legal.
- dp_mask  input  4  decimal-point enable per digit; bit i lights the point on digit i.
- blank_lz  input  1  1 = blank leading zeros on digits 3..1.
- display_en  input  1  0 = all digits dark; scanning continues.
- an  output  4  anode selects, active low; an[i] = 0 lights digit i.
- sseg  output  8  segments, active low, {dp,g,f,e,d,c,b,a}.
- frame_tick  output  1  one-cycle pulse when a new snapshot is loaded.

Behaviour:
- One clock domain. Reset is synchronous and active-high; the polarity and synchronicity are fixed.
- Reset values:
  - dwell counter = 0, sel = 0, snapshot digits = 16'h0000, snapshot dp = 4'b0000.
  - an = 4'b1111, sseg = 8'hFF, frame_tick = 0.
- Dwell counter:
  - Counts 0..DVSR-1 and wraps to 0.
  - sel (2 bits) increments when the counter = DVSR-1; sel wraps 3 -> 0.
- Snapshot:
  - When counter = DVSR-1 and sel = 3, digits and dp_mask load into the snapshot registers on that edge.
  - frame_tick is registered and is high for the cycle after that edge.
  - Input changes at any other time have no effect until the next frame boundary.
  - The first frame after reset shows the reset snapshot (0000).
- Output pipeline:
  - an and sseg are registered and reflect the sel and snapshot state of the previous cycle (1-cycle latency).
  - The first edge after reset release gives an = 4'b1110.
- Anode: an = ~(4'b0001 << sel) when display_en = 1; otherwise 4'b1111. sseg = 8'hFF whenever display_en = 0.
- Segment encoding, hex of {g..a} active low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking, with blank_lz sampled live each cycle:
  - Digit i (i = 3..1) is blank (g..a = 7'h7F) when it is 0 and every higher digit is also 0.
  - Digit 0 is never blanked.
  - A non-zero higher digit forces all lower zeros to display.
- Decimal point: sseg[7] = ~snapshot_dp[sel]. The point is driven even on a blanked digit.
- Simultaneous events: reset overrides everything, including a snapshot edge.
- Reset mid-scan: on the next edge the block returns to the reset state, with display dark for one cycle.

Test Plan:
1. DVSR=4, reset held 3 cycles then released, digits=16'h1234 applied immediately:
   - an is 1111 during reset, then 1110 with sseg=8'hC0 for 4 cycles; digits 1,2,3 then show 0 with blank_lz=0.
   - frame_tick pulses at cycle 16.
   - The next frame shows an=1110/sseg=8'h99, 1101/B0, 1011/A4, 0111/F9.
2. digits changed from 16'h1234 to 16'h5678 while sel=1 -> the current frame still shows 1234 digits; 5678 appears only after the next frame_tick.
3. blank_lz=1, digits=16'h0070:
   - digit3 and digit2 give sseg=8'hFF; digit1 gives F8; digit0 gives C0.
   - With digits=16'h0000, only digit0 is lit (C0).
4. dp_mask=4'b0100, digits=16'h0595 (time 05.95) -> digit2 gives sseg=8'h12 (dp low, '5'); the other digits have bit7=1.
5. display_en=0 mid-frame -> an=1111 and sseg=FF on the next cycle; frame_tick still pulses every 4·DVSR cycles; scan position is preserved when display_en is re-asserted.
6. Reset asserted during sel=2 -> next cycle an=1111, sseg=FF, snapshot=0. After release the scan restarts at digit0 with 0000 displayed.
